conf_int_div_seq: RTL and testbench

- Sequential restoring integer divider: the inverse-operation companion of the team's configurable integer multiplier.
- Shares the same racc/rapx reconfiguration inputs and the OP_BITWIDTH / DATA_PATH_BITWIDTH parameterisation.
- Unlike the flop-free multiplier, this block is iterative: one quotient bit per cycle, with a start/done handshake.
- Approximate mode skips the low quotient iterations, trading accuracy for latency and energy.

---
 rtl/conf_int_div_seq_pkg.sv | 27 ++
 rtl/conf_int_div_seq_step.sv | 32 +++
 rtl/conf_int_div_seq.sv | 163 ++++++++++++++++
 tb/tb_conf_int_div_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/conf_int_div_seq_pkg.sv
// Shared definitions for the configurable integer divider: FSM/mode encodings
// and the iteration-count helper used across the multiplier/divider family.
package conf_int_div_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_ACC = 1'b0,
        MODE_APX = 1'b1
    } mode_e;

    // Approximate mode drops the low apx_bits quotient iterations.
    function automatic int unsigned calc_iter(input mode_e mode,
                                              input int unsigned op_bits,
                                              input int unsigned apx_bits);
        if (mode == MODE_APX) begin
            return op_bits - apx_bits;
        end else begin
            return op_bits;
        end
    endfunction

endpackage

// File: rtl/conf_int_div_seq_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder, trial-subtract the divisor, keep or restore.
module conf_int_div_seq_step
    import conf_int_div_seq_pkg::*;
#(
    parameter int OP_BITWIDTH = 16
) (
    input  logic [OP_BITWIDTH:0]   rem_i,
    input  logic [OP_BITWIDTH-1:0] div_i,
    input  logic                   bit_i,
    output logic [OP_BITWIDTH:0]   rem_o,
    output logic                   q_bit_o
);

    logic [OP_BITWIDTH:0] shifted;
    logic [OP_BITWIDTH:0] diff;

    // rem_i < divisor always holds, so the shift cannot overflow and the
    // MSB of the difference is a clean sign bit.
    always_comb begin
        shifted = {rem_i[OP_BITWIDTH-1:0], bit_i};
        diff    = shifted - {1'b0, div_i};
        if (diff[OP_BITWIDTH] == 1'b0) begin
            rem_o   = diff;
            q_bit_o = 1'b1;
        end else begin
            rem_o   = shifted;
            q_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/conf_int_div_seq.sv
// Sequential restoring divider with start/done handshake and an approximate
// mode that stops after the high quotient bits.
module conf_int_div_seq
    import conf_int_div_seq_pkg::*;
#(
    parameter int OP_BITWIDTH        = 16,
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int APX_BITS           = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          racc,
    input  logic                          rapx,
    input  logic                          start,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_PATH_BITWIDTH-1:0] q,
    output logic [DATA_PATH_BITWIDTH-1:0] r,
    output logic                          div_by_zero
);

    localparam int CNT_W = $clog2(OP_BITWIDTH + 1);

    state_e                        state_q, state_d;
    mode_e                         mode_q, mode_d;
    mode_e                         start_mode;
    logic [OP_BITWIDTH-1:0]        dvd_q, dvd_d;
    logic [OP_BITWIDTH-1:0]        div_q, div_d;
    logic [OP_BITWIDTH-1:0]        quo_q, quo_d;
    logic [OP_BITWIDTH:0]          rem_q, rem_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [DATA_PATH_BITWIDTH-1:0] q_q, q_d;
    logic [DATA_PATH_BITWIDTH-1:0] r_q, r_d;
    logic                          dbz_q, dbz_d;

    logic [OP_BITWIDTH-1:0]        a_op, b_op;
    logic [OP_BITWIDTH:0]          step_rem;
    logic                          step_qbit;
    logic [OP_BITWIDTH-1:0]        quo_next;
    logic [DATA_PATH_BITWIDTH-1:0] q_calc, r_calc;

    assign a_op       = a[OP_BITWIDTH-1:0];
    assign b_op       = b[OP_BITWIDTH-1:0];
    assign start_mode = (!racc && rapx) ? MODE_APX : MODE_ACC;

    conf_int_div_seq_step #(
        .OP_BITWIDTH(OP_BITWIDTH)
    ) u_step (
        .rem_i   (rem_q),
        .div_i   (div_q),
        .bit_i   (dvd_q[OP_BITWIDTH-1]),
        .rem_o   (step_rem),
        .q_bit_o (step_qbit)
    );

    // Next-state, datapath and result computation.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        dvd_d    = dvd_q;
        div_d    = div_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        q_d      = q_q;
        r_d      = r_q;
        dbz_d    = dbz_q;
        quo_next = {quo_q[OP_BITWIDTH-2:0], step_qbit};
        q_calc   = '0;
        r_calc   = '0;
        if (mode_q == MODE_APX) begin
            q_calc[OP_BITWIDTH-1:0] = quo_next << APX_BITS;
        end else begin
            q_calc[OP_BITWIDTH-1:0] = quo_next;
        end
        r_calc[OP_BITWIDTH-1:0] = step_rem[OP_BITWIDTH-1:0];

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && (b_op == '0)) begin
                    state_d                = ST_DONE;
                    q_d                    = '0;
                    q_d[OP_BITWIDTH-1:0]   = {OP_BITWIDTH{1'b1}};
                    r_d                    = '0;
                    r_d[OP_BITWIDTH-1:0]   = a_op;
                    dbz_d                  = 1'b1;
                end else if (start) begin
                    state_d = ST_CALC;
                    mode_d  = start_mode;
                    dvd_d   = a_op;
                    div_d   = b_op;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = CNT_W'(calc_iter(start_mode, OP_BITWIDTH, APX_BITS));
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                rem_d = step_rem;
                quo_d = quo_next;
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    q_d     = q_calc;
                    r_d     = r_calc;
                    dbz_d   = 1'b0;
                end else begin
                    state_d = ST_CALC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and registered outputs; rst overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_ACC;
            dvd_q   <= '0;
            div_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dvd_q   <= dvd_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign q           = q_q;
    assign r           = r_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_conf_int_div_seq.sv
// Directed self-checking bench for conf_int_div_seq (16-bit, APX_BITS=8).
module tb_conf_int_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        racc;
    logic        rapx;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;

    int n_cmp = 0;
    int n_err = 0;

    conf_int_div_seq #(
        .OP_BITWIDTH        (16),
        .DATA_PATH_BITWIDTH (16),
        .APX_BITS           (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .racc        (racc),
        .rapx        (rapx),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (dbz)
    );

    always #5 clk = ~clk;

    // Drives a start pulse; returns 1 us after the sampling edge (edge 1).
    task automatic drive_start(input logic [15:0] ai, input logic [15:0] bi,
                               input logic ra, input logic rp);
        @(negedge clk);
        a = ai; b = bi; racc = ra; rapx = rp; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges (sampling edge = 1) until done; bounded.
    task automatic wait_done(input int first, output int edges);
        edges = first;
        while (done !== 1'b1 && edges < 64) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; racc = 1'b0; rapx = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, q, r, dbz} !== 35'd0) begin
            n_err++;
            $display("FAIL reset: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b, exp all 0", busy, done, q, r, dbz);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_accurate();
        int e;
        drive_start(16'd100, 16'd7, 1'b1, 1'b0);
        wait_done(1, e);
        n_cmp++;
        if (e !== 17 || q !== 16'd14 || r !== 16'd2 || dbz !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL acc_100_7: got edge=%0d q=%0d r=%0d dbz=%0b busy=%0b, exp 17 14 2 0 0", e, q, r, dbz, busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (done !== 1'b0 || q !== 16'd14) begin
            n_err++;
            $display("FAIL done_pulse: got done=%0b q=%0d, exp done=0 q=14", done, q);
        end
    endtask

    task automatic test_extremes();
        int e;
        drive_start(16'hFFFF, 16'd1, 1'b1, 1'b0);
        wait_done(1, e);
        n_cmp++;
        if (e !== 17 || q !== 16'hFFFF || r !== 16'd0) begin
            n_err++;
            $display("FAIL acc_ffff_1: got edge=%0d q=%h r=%h, exp 17 ffff 0000", e, q, r);
        end
        drive_start(16'd5, 16'd9, 1'b0, 1'b0);
        wait_done(1, e);
        n_cmp++;
        if (e !== 17 || q !== 16'd0 || r !== 16'd5) begin
            n_err++;
            $display("FAIL acc_a_lt_b: got edge=%0d q=%0d r=%0d, exp 17 0 5", e, q, r);
        end
    endtask

    task automatic test_approx();
        int e;
        drive_start(16'd1000, 16'd3, 1'b0, 1'b1);
        wait_done(1, e);
        n_cmp++;
        if (e !== 9 || q !== 16'd256 || r !== 16'd0 || dbz !== 1'b0) begin
            n_err++;
            $display("FAIL apx_1000_3: got edge=%0d q=%0d r=%0d dbz=%0b, exp 9 256 0 0", e, q, r, dbz);
        end
        drive_start(16'd1000, 16'd3, 1'b1, 1'b1);
        wait_done(1, e);
        n_cmp++;
        if (e !== 17 || q !== 16'd333 || r !== 16'd1) begin
            n_err++;
            $display("FAIL racc_wins: got edge=%0d q=%0d r=%0d, exp 17 333 1", e, q, r);
        end
    endtask

    task automatic test_div_zero();
        int e;
        drive_start(16'h1234, 16'd0, 1'b1, 1'b0);
        wait_done(1, e);
        n_cmp++;
        if (e !== 1 || q !== 16'hFFFF || r !== 16'h1234 || dbz !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL div_zero: got edge=%0d q=%h r=%h dbz=%0b busy=%0b, exp 1 ffff 1234 1 0", e, q, r, dbz, busy);
        end
        drive_start(16'd10, 16'd3, 1'b1, 1'b0);
        wait_done(1, e);
        n_cmp++;
        if (e !== 17 || q !== 16'd3 || r !== 16'd1 || dbz !== 1'b0) begin
            n_err++;
            $display("FAIL dbz_clear: got edge=%0d q=%0d r=%0d dbz=%0b, exp 17 3 1 0", e, q, r, dbz);
        end
    endtask

    task automatic test_back_to_back();
        int e;
        drive_start(16'd100, 16'd7, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        a = 16'd9; b = 16'd3; racc = 1'b0; rapx = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL busy_mid: got busy=%0b done=%0b, exp 1 0", busy, done);
        end
        wait_done(5, e);
        n_cmp++;
        if (e !== 17 || q !== 16'd14 || r !== 16'd2) begin
            n_err++;
            $display("FAIL start_ignored: got edge=%0d q=%0d r=%0d, exp 17 14 2", e, q, r);
        end
        // Start issued inside the DONE cycle.
        a = 16'd200; b = 16'd13; racc = 1'b1; rapx = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || done !== 1'b0 || q !== 16'd14) begin
            n_err++;
            $display("FAIL b2b_accept: got busy=%0b done=%0b q=%0d, exp 1 0 14", busy, done, q);
        end
        wait_done(1, e);
        n_cmp++;
        if (e !== 17 || q !== 16'd15 || r !== 16'd5) begin
            n_err++;
            $display("FAIL b2b_result: got edge=%0d q=%0d r=%0d, exp 17 15 5", e, q, r);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        bit seen;
        drive_start(16'd100, 16'd7, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 16'd0 || r !== 16'd0 || dbz !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: got busy=%0b done=%0b q=%0d r=%0d dbz=%0b, exp all 0", busy, done, q, r, dbz);
        end
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        repeat (24) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_done: got done seen=%0b, exp 0", seen);
        end
        drive_start(16'd200, 16'd13, 1'b1, 1'b0);
        wait_done(1, e);
        n_cmp++;
        if (e !== 17 || q !== 16'd15 || r !== 16'd5 || dbz !== 1'b0) begin
            n_err++;
            $display("FAIL after_rst: got edge=%0d q=%0d r=%0d dbz=%0b, exp 17 15 5 0", e, q, r, dbz);
        end
    endtask

    initial begin
        test_reset();
        test_accurate();
        test_extremes();
        test_approx();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
